// File: rtl/shuffle_buffer_if.sv
// shuffle_buffer_if: handshake and control bundle of the shuffle buffer.
// Upstream write, downstream read, pick request and slot-status signals.
interface shuffle_buffer_if #(
  parameter int BS = 16,
  parameter int DW = 32
);
  localparam int IW = $clog2(BS);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic [BS-1:0] cand_list;
  logic          start;
  logic [IW-1:0] buffer_index;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [IW:0]   occ;

  modport slave (
    input  in_valid, in_data, flush,
    input  buffer_index, out_ready,
    output in_ready, cand_list, start,
    output out_valid, out_data, occ
  );

  modport master (
    output in_valid, in_data, flush,
    output buffer_index, out_ready,
    input  in_ready, cand_list, start,
    input  out_valid, out_data, occ
  );
endinterface

// File: rtl/shuffle_buffer.sv
// shuffle_buffer: slot store feeding a random-pick mapping table.
// Ports: clk, rst (sync, active-low), bus (shuffle_buffer_if.slave);
// with SHUF_RETRY_STATS_EN also retry_cnt[15:0] and retry_cnt_sat.
module shuffle_buffer #(
  parameter int BS     = 16,
  parameter int DW     = 32,
  parameter int THRESH = 8
) (
  input  logic clk,
  input  logic rst,
  shuffle_buffer_if.slave bus
`ifdef SHUF_RETRY_STATS_EN
  ,
  output logic [15:0] retry_cnt,
  output logic        retry_cnt_sat
`endif
);
  localparam int IW = $clog2(BS);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, LOAD, OUT
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] mem [BS];
  logic [BS-1:0] mask;
  logic [BS-1:0] mask_nxt;
  logic [BS-1:0] wr_oh;
  logic [BS-1:0] rel_oh;
  logic [IW:0]   occ_q;
  logic [IW-1:0] sel;
  logic [IW-1:0] free_idx;
  logic [DW-1:0] dout;
  logic          ready;
  logic          wr;
  logic          rel;
  logic          hit;
  logic          load_hit;
  logic          miss;
  logic          start_c;
  logic          oval_c;
  logic          go;

  assign ready = occ_q != (IW+1)'(BS);
  assign wr    = bus.in_valid && ready;
  assign rel   = (state == OUT) && bus.out_ready;
  assign hit   = mask[bus.buffer_index];
  assign go    = (occ_q >= (IW+1)'(THRESH)) ||
                 (bus.flush && occ_q != '0);

  // lowest free slot, taken from the pre-edge mask
  always_comb begin
    free_idx = '0;
    for (int i = BS - 1; i >= 0; i--)
      if (!mask[i]) free_idx = IW'(i);
  end

  // write and release slots never coincide:
  // one is clear, the other is set
  always_comb begin
    wr_oh           = '0;
    rel_oh          = '0;
    wr_oh[free_idx] = wr;
    rel_oh[sel]     = rel;
    mask_nxt        = (mask | wr_oh) & ~rel_oh;
  end

  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    oval_c    = 1'b0;
    load_hit  = 1'b0;
    miss      = 1'b0;
    unique case (state)
      IDLE: if (go) state_nxt = REQ;
      REQ: begin
        start_c   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: state_nxt = LOAD;
      LOAD: begin
        if (hit) begin
          load_hit  = 1'b1;
          state_nxt = OUT;
        end else begin
          miss      = 1'b1;
          state_nxt = REQ;
        end
      end
      OUT: begin
        oval_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      mask  <= '0;
      occ_q <= '0;
      sel   <= '0;
      dout  <= '0;
    end else begin
      state <= state_nxt;
      mask  <= mask_nxt;
      occ_q <= occ_q + {{IW{1'b0}}, wr}
                     - {{IW{1'b0}}, rel};
      if (load_hit) begin
        dout <= mem[bus.buffer_index];
        sel  <= bus.buffer_index;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[free_idx] <= bus.in_data;
  end

`ifdef SHUF_RETRY_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst)
      retry_cnt <= '0;
    else if (miss && !retry_cnt_sat)
      retry_cnt <= retry_cnt + 16'd1;
  end

  assign retry_cnt_sat = retry_cnt == 16'hFFFF;
`endif

  assign bus.in_ready  = ready;
  assign bus.cand_list = mask;
  assign bus.occ       = occ_q;
  assign bus.start     = start_c;
  assign bus.out_valid = oval_c;
  assign bus.out_data  = dout;
endmodule

// File: tb/tb_shuffle_buffer.sv
// tb_shuffle_buffer: directed plus random bench for shuffle_buffer.
// Slot-level reference model, per-cycle compare, summary at end.
module tb_shuffle_buffer;
  localparam int BS     = 16;
  localparam int DW     = 32;
  localparam int THRESH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shuffle_buffer_if #(.BS(BS), .DW(DW)) bus ();

`ifdef SHUF_RETRY_STATS_EN
  logic [15:0] retry_cnt;
  logic        retry_cnt_sat;
`endif

  shuffle_buffer #(
    .BS(BS), .DW(DW), .THRESH(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef SHUF_RETRY_STATS_EN
    ,
    .retry_cnt(retry_cnt),
    .retry_cnt_sat(retry_cnt_sat)
`endif
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(string name,
                     logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // reference model: slot set, output slot and pick timeline
  logic [BS-1:0] m_mask = '0;
  logic [DW-1:0] m_mem [BS];
  int            m_age   = 0;
  bit            m_ov    = 1'b0;
  logic [DW-1:0] m_od    = '0;
  int            m_idx   = 0;
  int            m_retry = 0;

  function automatic int low_free(logic [BS-1:0] m);
    for (int i = 0; i < BS; i++)
      if (!m[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    int occ_now;
    int slot;
    int bi;
    logic [BS-1:0] nm;
    occ_now = $countones(m_mask);
    nm      = m_mask;
    bi      = int'(bus.buffer_index);
    if (!rst) begin
      m_mask  = '0;
      m_age   = 0;
      m_ov    = 1'b0;
      m_od    = '0;
      m_retry = 0;
      return;
    end
    if (m_ov && bus.out_ready) begin
      nm[m_idx] = 1'b0;
      m_ov      = 1'b0;
    end else if (!m_ov) begin
      if (m_age == 0) begin
        if (occ_now >= THRESH ||
            (bus.flush && occ_now > 0))
          m_age = 1;
      end else if (m_age < 3) begin
        m_age++;
      end else if (m_mask[bi]) begin
        m_ov  = 1'b1;
        m_od  = m_mem[bi];
        m_idx = bi;
        m_age = 0;
      end else begin
        m_age = 1;
        if (m_retry < 65535) m_retry++;
      end
    end
    if (bus.in_valid && occ_now < BS) begin
      slot        = low_free(m_mask);
      nm[slot]    = 1'b1;
      m_mem[slot] = bus.in_data;
    end
    m_mask = nm;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cand_list", bus.cand_list, m_mask);
      chk("occ", bus.occ, $countones(m_mask));
      chk("in_ready", bus.in_ready,
          $countones(m_mask) != BS);
      chk("start", bus.start, m_age == 1);
      chk("out_valid", bus.out_valid, m_ov);
      chk("out_data", bus.out_data, m_od);
`ifdef SHUF_RETRY_STATS_EN
      chk("retry_cnt", retry_cnt, m_retry);
      chk("retry_sat", retry_cnt_sat,
          m_retry == 65535);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_wait"}, bus.out_valid, 1);
  endtask

  initial begin
    int emitted;
    int n;
`ifdef SHUF_RETRY_STATS_EN
    logic [15:0] r0;
`endif
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;
    bus.buffer_index = '0;
    rst = 1'b0;
    tick();
    tick();
    cmp_en = 1'b1;
    rst    = 1'b1;
    chk("rst_cand", bus.cand_list, 0);
    chk("rst_occ", bus.occ, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_od", bus.out_data, 0);
    chk("rst_rdy", bus.in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA0 + i;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("fill_cand", bus.cand_list, 16'h00FF);
    chk("fill_occ", bus.occ, 8);
    chk("fill_nostart", bus.start, 0);
    tick();
    chk("fill_start", bus.start, 1);
    bus.buffer_index = 4'd3;
    bus.out_ready    = 1'b1;
    tick();
    chk("pick_start_off", bus.start, 0);
    chk("pick_ov_wait", bus.out_valid, 0);
    tick();
    chk("pick_ov_load", bus.out_valid, 0);
    tick();
    chk("pick_ov", bus.out_valid, 1);
    chk("pick_od", bus.out_data, 32'hA3);
    tick();
    chk("pick_cand", bus.cand_list, 16'h00F7);
    chk("pick_occ", bus.occ, 7);
    chk("pick_ov_off", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    bus.buffer_index = 4'd12;
    bus.in_valid     = 1'b1;
    bus.in_data      = 32'hB0;
    tick();
    bus.in_valid = 1'b0;
    chk("stale_cand", bus.cand_list, 16'h00FF);
    tick();
    chk("stale_start", bus.start, 1);
`ifdef SHUF_RETRY_STATS_EN
    r0 = retry_cnt;
`endif
    tick();
    chk("stale_s1", bus.start, 0);
    tick();
    chk("stale_s2", bus.start, 0);
    tick();
    chk("stale_restart", bus.start, 1);
    chk("stale_ov", bus.out_valid, 0);
`ifdef SHUF_RETRY_STATS_EN
    chk("stale_retry", retry_cnt, r0 + 16'd1);
`endif

    bus.buffer_index = 4'd5;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hC0 + i;
      tick();
    end
    bus.in_data = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_rdy", bus.in_ready, 0);
      chk("full_occ", bus.occ, 16);
    end
    chk("full_ov", bus.out_valid, 1);
    chk("full_od", bus.out_data, 32'hA5);
    bus.out_ready = 1'b1;
    bus.in_data   = 32'hD0;
    tick();
    bus.out_ready = 1'b0;
    chk("rel_occ", bus.occ, 15);
    chk("rel_rdy", bus.in_ready, 1);
    chk("rel_cand", bus.cand_list, 16'hFFDF);
    tick();
    bus.in_valid = 1'b0;
    chk("refill_cand", bus.cand_list, 16'hFFFF);
    chk("refill_occ", bus.occ, 16);
    wait_ov("slot5");
    chk("slot5_od", bus.out_data, 32'hD0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready    = 1'b0;
    bus.buffer_index = 4'd7;
    wait_ov("slot7");
    chk("slot7_od", bus.out_data, 32'hA7);
    chk("slot7_occ", bus.occ, 15);
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hE0;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("simul_occ", bus.occ, 15);
    chk("simul_cand", bus.cand_list, 16'hFF7F);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hF0 + i;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    emitted = 0;
    n = 0;
    while (n < 300 &&
           !(emitted == 3 && bus.occ == 0 &&
             !bus.out_valid)) begin
      if (bus.out_valid) emitted++;
      bus.buffer_index = 4'($urandom_range(0, 2));
      tick();
      n++;
    end
    chk("flush_emitted", emitted, 3);
    chk("flush_occ", bus.occ, 0);
    chk("flush_cand", bus.cand_list, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("flush_idle", bus.start, 0);
    end
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    bus.buffer_index = 4'd2;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h60 + i;
      tick();
    end
    bus.in_valid = 1'b0;
    wait_ov("mid");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_ov", bus.out_valid, 0);
    chk("mid_occ", bus.occ, 0);
    chk("mid_cand", bus.cand_list, 0);
    chk("mid_start", bus.start, 0);
    tick();
    chk("mid_idle", bus.start, 0);

    for (int i = 0; i < 3000; i++) begin
      bus.in_valid     = 1'($urandom_range(0, 1));
      bus.in_data      = $urandom;
      bus.flush        = ($urandom_range(0, 3) == 0);
      bus.out_ready    = 1'($urandom_range(0, 1));
      bus.buffer_index = 4'($urandom_range(0, BS - 1));
      rst = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
